// File: rtl/sync_ppfifo.sv
// Two-buffer ping-pong FIFO: the producer fills one buffer while the consumer drains the other.
// Buffers are handed over whole; the consumer always receives the oldest committed buffer first.
module sync_ppfifo #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [1:0]            o_write_ready,
  input  logic [1:0]            i_write_activate,
  output logic [23:0]           o_write_size,
  input  logic                  i_write_stb,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic                  o_read_ready,
  input  logic                  i_read_activate,
  output logic [23:0]           o_read_size,
  input  logic                  i_read_stb,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_inactive,
  output logic                  o_error
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam int unsigned CW    = ADDRESS_WIDTH + 1;

  localparam logic [1:0] ST_EMPTY     = 2'd0;
  localparam logic [1:0] ST_WRITING   = 2'd1;
  localparam logic [1:0] ST_COMMITTED = 2'd2;
  localparam logic [1:0] ST_READING   = 2'd3;

  logic [1:0][1:0]    state, state_n;
  logic [1:0][CW-1:0] buf_count, buf_count_n;
  logic               wr_idx, wr_idx_n;
  logic               rd_idx, rd_idx_n;
  logic               oldest, oldest_n;
  logic [CW-1:0]      wr_count, wr_count_n;
  logic [CW-1:0]      rd_ptr, rd_ptr_n;
  logic [1:0]         wr_act_q;
  logic               rd_act_q;
  logic [1:0]         write_ready_n;
  logic               read_ready_n;
  logic [23:0]        read_size_n;
  logic               inactive_n;
  logic               error_n;

  logic               wr_busy, rd_busy, wr_en;
  logic [1:0]         wr_onehot, wr_rise;
  logic               rd_rise, rd_fall;

  logic [DATA_WIDTH-1:0] mem [2*DEPTH];

  assign o_write_size = 24'(DEPTH);
  assign wr_busy      = (state[wr_idx] == ST_WRITING);
  assign rd_busy      = (state[rd_idx] == ST_READING);
  assign wr_onehot    = wr_idx ? 2'b10 : 2'b01;
  assign wr_rise      = i_write_activate & ~wr_act_q;
  assign rd_rise      = i_read_activate & ~rd_act_q;
  assign rd_fall      = ~i_read_activate & rd_act_q;
  // Strobes only land while the producer still holds its own buffer and it has room.
  assign wr_en        = wr_busy && (i_write_activate == wr_onehot) && i_write_stb &&
                        (wr_count < CW'(DEPTH));

  assign o_read_data  = rd_busy ? mem[{rd_idx, rd_ptr[ADDRESS_WIDTH-1:0]}] : '0;

  // Next-state and registered-output decode.
  always_comb begin
    state_n     = state;
    buf_count_n = buf_count;
    wr_idx_n    = wr_idx;
    rd_idx_n    = rd_idx;
    oldest_n    = oldest;
    wr_count_n  = wr_count;
    rd_ptr_n    = rd_ptr;
    read_size_n = o_read_size;
    error_n     = 1'b0;

    if (wr_busy) begin
      if (i_write_activate != wr_act_q) begin
        if (i_write_activate == 2'b00) begin
          if (wr_count != '0) begin
            state_n[wr_idx]     = ST_COMMITTED;
            buf_count_n[wr_idx] = wr_count;
            if (state[~wr_idx] != ST_COMMITTED) oldest_n = wr_idx;
          end else begin
            state_n[wr_idx] = ST_EMPTY;
          end
          wr_count_n = '0;
        end else if (i_write_activate != wr_onehot) begin
          error_n = 1'b1;
        end
      end
    end else if (wr_rise != 2'b00) begin
      if (i_write_activate == 2'b11) begin
        error_n = 1'b1;
      end else if ((state[i_write_activate[1]] == ST_EMPTY) && o_write_ready[i_write_activate[1]]) begin
        state_n[i_write_activate[1]] = ST_WRITING;
        wr_idx_n                     = i_write_activate[1];
        wr_count_n                   = '0;
      end else begin
        error_n = 1'b1;
      end
    end

    if (wr_en) wr_count_n = wr_count + CW'(1);

    // A claim always takes the oldest buffer, so the other one becomes the next oldest.
    if (rd_rise) begin
      if (o_read_ready) begin
        state_n[oldest] = ST_READING;
        rd_idx_n        = oldest;
        oldest_n        = ~oldest;
        rd_ptr_n        = '0;
        read_size_n     = 24'(buf_count[oldest]);
      end else begin
        error_n = 1'b1;
      end
    end else if (rd_fall && rd_busy) begin
      state_n[rd_idx] = ST_EMPTY;
      rd_ptr_n        = '0;
      read_size_n     = '0;
    end else if (rd_busy && i_read_stb && (24'(rd_ptr) < o_read_size)) begin
      rd_ptr_n = rd_ptr + CW'(1);
    end

    write_ready_n[0] = (state_n[0] == ST_EMPTY);
    write_ready_n[1] = (state_n[1] == ST_EMPTY);
    read_ready_n     = ((state_n[0] == ST_COMMITTED) || (state_n[1] == ST_COMMITTED)) &&
                       (state_n[0] != ST_READING) && (state_n[1] != ST_READING);
    inactive_n       = (state_n[0] == ST_EMPTY) && (state_n[1] == ST_EMPTY) &&
                       (i_write_activate == 2'b00) && !i_read_activate;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= {ST_EMPTY, ST_EMPTY};
      buf_count     <= '0;
      wr_idx        <= 1'b0;
      rd_idx        <= 1'b0;
      oldest        <= 1'b0;
      wr_count      <= '0;
      rd_ptr        <= '0;
      wr_act_q      <= 2'b00;
      rd_act_q      <= 1'b0;
      o_write_ready <= 2'b11;
      o_read_ready  <= 1'b0;
      o_read_size   <= '0;
      o_inactive    <= 1'b1;
      o_error       <= 1'b0;
    end else begin
      state         <= state_n;
      buf_count     <= buf_count_n;
      wr_idx        <= wr_idx_n;
      rd_idx        <= rd_idx_n;
      oldest        <= oldest_n;
      wr_count      <= wr_count_n;
      rd_ptr        <= rd_ptr_n;
      wr_act_q      <= i_write_activate;
      rd_act_q      <= i_read_activate;
      o_write_ready <= write_ready_n;
      o_read_ready  <= read_ready_n;
      o_read_size   <= read_size_n;
      o_inactive    <= inactive_n;
      o_error       <= error_n;
    end
  end

  // Buffer storage; contents survive reset since counts gate every access.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_idx, wr_count[ADDRESS_WIDTH-1:0]}] <= i_write_data;
  end

endmodule

// File: tb/tb_sync_ppfifo.sv
// Bench for sync_ppfifo: directed producer/consumer sequences with a queue-based read scoreboard.
module tb_sync_ppfifo;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    o_write_ready;
  logic [1:0]    i_write_activate;
  logic [23:0]   o_write_size;
  logic          i_write_stb;
  logic [DW-1:0] i_write_data;
  logic          o_read_ready;
  logic          i_read_activate;
  logic [23:0]   o_read_size;
  logic          i_read_stb;
  logic [DW-1:0] o_read_data;
  logic          o_inactive;
  logic          o_error;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] data_q[$];
  logic [23:0]   size_q[$];
  logic [23:0]   prev_size = '0;
  logic [DW-1:0] exp_d;
  logic [23:0]   exp_s;

  sync_ppfifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .o_write_ready    (o_write_ready),
    .i_write_activate (i_write_activate),
    .o_write_size     (o_write_size),
    .i_write_stb      (i_write_stb),
    .i_write_data     (i_write_data),
    .o_read_ready     (o_read_ready),
    .i_read_activate  (i_read_activate),
    .o_read_size      (o_read_size),
    .i_read_stb       (i_read_stb),
    .o_read_data      (o_read_data),
    .o_inactive       (o_inactive),
    .o_error          (o_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic write_buf(input int b, input int n, input logic [DW-1:0] base);
    i_write_activate = (b == 1) ? 2'b10 : 2'b01;
    tick();
    check("wr_claim_ready_bit", 32'(o_write_ready[b]), 32'd0);
    for (int i = 0; i < n; i++) begin
      i_write_stb  = 1'b1;
      i_write_data = base + DW'(i);
      tick();
    end
    i_write_stb      = 1'b0;
    i_write_activate = 2'b00;
    tick();
  endtask

  task automatic read_buf(input logic [23:0] size, input int n, input logic [DW-1:0] base);
    size_q.push_back(size);
    i_read_activate = 1'b1;
    tick();
    check("rd_claim_ready_low", 32'(o_read_ready), 32'd0);
    for (int i = 0; i < n; i++) begin
      data_q.push_back(base + DW'(i));
      i_read_stb = 1'b1;
      tick();
    end
    i_read_stb      = 1'b0;
    i_read_activate = 1'b0;
    tick();
  endtask

  // Monitor: compares each strobed read word and each newly claimed size against the queues.
  always @(negedge clk) begin
    if (!rst && i_read_stb) begin
      checks++;
      if (data_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got unexpected word %0h, required none", o_read_data);
      end else begin
        exp_d = data_q.pop_front();
        if (o_read_data !== exp_d) begin
          errors++;
          $display("FAIL rd_data: got %0h required %0h", o_read_data, exp_d);
        end
      end
    end
    if (!rst && o_read_size != 24'd0 && prev_size == 24'd0) begin
      checks++;
      if (size_q.size() == 0) begin
        errors++;
        $display("FAIL rd_size: got unexpected size %0d, required none", o_read_size);
      end else begin
        exp_s = size_q.pop_front();
        if (o_read_size !== exp_s) begin
          errors++;
          $display("FAIL rd_size: got %0d required %0d", o_read_size, exp_s);
        end
      end
    end
    prev_size = o_read_size;
  end

  initial begin
    rst              = 1'b1;
    i_write_activate = 2'b00;
    i_write_stb      = 1'b0;
    i_write_data     = '0;
    i_read_activate  = 1'b0;
    i_read_stb       = 1'b0;
    tick();
    tick();
    check("rst_write_ready", 32'(o_write_ready), 32'h3);
    check("rst_read_ready", 32'(o_read_ready), 32'd0);
    check("rst_read_size", 32'(o_read_size), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    check("rst_inactive", 32'(o_inactive), 32'd1);
    check("rst_read_data", o_read_data, 32'd0);
    check("write_size", 32'(o_write_size), 32'd16);
    rst = 1'b0;
    tick();

    // Full buffer 0 with 0..15
    write_buf(0, 16, 32'd0);
    check("full_write_ready", 32'(o_write_ready), 32'h2);
    check("full_read_ready", 32'(o_read_ready), 32'd1);
    read_buf(24'd16, 16, 32'd0);
    check("full_after_ready", 32'(o_write_ready), 32'h3);
    check("full_after_rdy", 32'(o_read_ready), 32'd0);
    check("full_after_size", 32'(o_read_size), 32'd0);

    // Saturation: 20 strobes into 16 words
    write_buf(1, 20, 32'd100);
    read_buf(24'd16, 16, 32'd100);

    // Commit order: buffer 1 first, then buffer 0
    write_buf(1, 3, 32'd200);
    write_buf(0, 5, 32'd300);
    check("order_read_ready", 32'(o_read_ready), 32'd1);
    read_buf(24'd3, 3, 32'd200);
    check("order_ready_again", 32'(o_read_ready), 32'd1);
    read_buf(24'd5, 5, 32'd300);

    // Empty activate/release
    i_write_activate = 2'b01;
    tick();
    i_write_activate = 2'b00;
    tick();
    check("empty_write_ready", 32'(o_write_ready), 32'h3);
    check("empty_read_ready", 32'(o_read_ready), 32'd0);
    check("empty_error", 32'(o_error), 32'd0);

    // Illegal activates
    i_write_activate = 2'b11;
    tick();
    check("err_both_pulse", 32'(o_error), 32'd1);
    check("err_both_ready", 32'(o_write_ready), 32'h3);
    tick();
    check("err_both_single", 32'(o_error), 32'd0);
    i_write_activate = 2'b00;
    tick();
    check("err_clear", 32'(o_error), 32'd0);
    i_read_activate = 1'b1;
    tick();
    check("err_read_pulse", 32'(o_error), 32'd1);
    check("err_read_size", 32'(o_read_size), 32'd0);
    check("err_read_ready", 32'(o_read_ready), 32'd0);
    tick();
    check("err_read_single", 32'(o_error), 32'd0);
    i_read_activate = 1'b0;
    tick();

    // Partial read then release frees the buffer
    write_buf(0, 8, 32'd400);
    read_buf(24'd8, 2, 32'd400);
    check("partial_write_ready", 32'(o_write_ready), 32'h3);
    check("partial_read_ready", 32'(o_read_ready), 32'd0);
    check("partial_inactive", 32'(o_inactive), 32'd1);

    // Reset in the middle of a write
    i_write_activate = 2'b10;
    tick();
    for (int i = 0; i < 3; i++) begin
      i_write_stb  = 1'b1;
      i_write_data = 32'd450 + DW'(i);
      tick();
    end
    check("midwr_inactive", 32'(o_inactive), 32'd0);
    check("midwr_ready", 32'(o_write_ready), 32'h1);
    rst              = 1'b1;
    i_write_stb      = 1'b0;
    i_write_activate = 2'b00;
    #1;
    check("midrst_write_ready", 32'(o_write_ready), 32'h3);
    check("midrst_inactive", 32'(o_inactive), 32'd1);
    check("midrst_read_ready", 32'(o_read_ready), 32'd0);
    tick();
    tick();

    // Activate on the first edge after reset release
    rst              = 1'b0;
    i_write_activate = 2'b01;
    tick();
    check("post_rst_claim", 32'(o_write_ready), 32'h2);
    for (int i = 0; i < 2; i++) begin
      i_write_stb  = 1'b1;
      i_write_data = 32'd500 + DW'(i);
      tick();
    end
    i_write_stb      = 1'b0;
    i_write_activate = 2'b00;
    tick();
    check("post_rst_read_ready", 32'(o_read_ready), 32'd1);
    read_buf(24'd2, 2, 32'd500);

    // Concurrent write of buffer 1 and read of buffer 0, commit and release on the same edge
    write_buf(0, 4, 32'd600);
    fork
      write_buf(1, 4, 32'd700);
      read_buf(24'd4, 4, 32'd600);
    join
    check("concurrent_read_ready", 32'(o_read_ready), 32'd1);
    check("concurrent_write_ready", 32'(o_write_ready), 32'h1);
    read_buf(24'd4, 4, 32'd700);

    tick();
    tick();
    check("sb_data_drained", 32'(data_q.size()), 32'd0);
    check("sb_size_drained", 32'(size_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_ppfifo.md
SYNC_PPFIFO -- requirements
Module: sync_ppfifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4, giving per-buffer depth 2^ADDRESS_WIDTH words (16 by default).
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port o_write_ready, output, 2 bits: bit n set means buffer n is empty and available to the producer.
REQ-006 SHALL have port i_write_activate, input, 2 bits: the producer's one-hot claim of a buffer.
REQ-007 SHALL have port o_write_size, output, 24 bits: constant 2^ADDRESS_WIDTH.
REQ-008 SHALL have port i_write_stb, input, 1 bit: the write strobe, one word per cycle.
REQ-009 SHALL have port i_write_data, input, DATA_WIDTH bits: the write word.
REQ-010 SHALL have port o_read_ready, output, 1 bit: a committed buffer is waiting for the consumer.
REQ-011 SHALL have port i_read_activate, input, 1 bit: the consumer's claim of the oldest committed buffer.
REQ-012 SHALL have port o_read_size, output, 24 bits: the word count of the claimed buffer.
REQ-013 SHALL have port i_read_stb, input, 1 bit: the read strobe, which advances the read pointer.
REQ-014 SHALL have port o_read_data, output, DATA_WIDTH bits: the word at the read pointer (show-ahead).
REQ-015 SHALL have port o_inactive, output, 1 bit: both buffers are empty and no activate is asserted.
REQ-016 SHALL have port o_error, output, 1 bit: one-cycle pulse on an illegal activate.

Function
REQ-017 SHALL keep a per-buffer state: EMPTY -> WRITING -> COMMITTED -> READING -> EMPTY.
REQ-018 On i_write_activate rising for a buffer that is EMPTY and whose ready bit is set, SHALL move that buffer to WRITING and clear its ready bit on the next cycle.
REQ-019 SHALL pulse o_error for one cycle and ignore the request when i_write_activate is 2'b11, or targets a non-ready buffer, or changes target while a buffer is WRITING.
REQ-020 For each i_write_stb while WRITING, SHALL store i_write_data at the write pointer and increment the count.
REQ-021 SHALL ignore strobes once the count equals 2^ADDRESS_WIDTH; the count saturates and does not wrap.
REQ-022 SHALL ignore i_write_stb when no buffer is WRITING.
REQ-023 On i_write_activate falling with count > 0, SHALL move the buffer to COMMITTED, record its count, and stamp its commit order.
REQ-024 On i_write_activate falling with count == 0, SHALL return the buffer to EMPTY and set its ready bit on the next cycle.
REQ-025 SHALL assert o_read_ready, registered, when some buffer is COMMITTED and no buffer is READING.
REQ-026 On i_read_activate rising while o_read_ready is set, SHALL move the oldest COMMITTED buffer to READING, load o_read_size with its count, reset the read pointer to 0, and deassert o_read_ready next cycle.
REQ-027 On i_read_activate rising while o_read_ready is clear, SHALL pulse o_error and take no other action.
REQ-028 SHALL present o_read_data combinationally from the read pointer while READING.
REQ-029 SHALL advance the read pointer on i_read_stb, so the next word appears the cycle after the strobe.
REQ-030 SHALL ignore read strobes once the pointer equals o_read_size.
REQ-031 On i_read_activate falling, SHALL return the READING buffer to EMPTY regardless of words consumed; unread words are discarded.
REQ-032 SHALL allow a simultaneous write to one buffer and read from the other every cycle with no stall.
REQ-033 When a write commit and a read release land in the same cycle, SHALL process both; commit order is unaffected.
REQ-034 SHALL hold o_read_size and o_read_data at 0 when not READING.

Reset
REQ-035 While rst is asserted, asynchronously: both buffers EMPTY, o_write_ready=2'b11, o_read_ready=0, o_read_size=0, o_error=0, o_inactive=1, all pointers and counts 0.
REQ-036 Reset mid-transfer SHALL discard all buffered data; memory contents need not clear.
REQ-037 After rst deasserts, the producer SHALL be able to activate a buffer on the first clock edge.

Verification
REQ-038 Reset then write 16 words (0..15) to buffer 0 and release -> o_write_ready=2'b10, o_read_ready=1; reading returns size 16 and data 0..15 in order.
REQ-039 Write 20 strobes into a depth-16 buffer -> count saturates at 16; words 16..19 are never read back.
REQ-040 Commit buffer 1 (3 words) then buffer 0 (5 words) -> the first read claims buffer 1 with o_read_size=3, the second claims buffer 0 with o_read_size=5.
REQ-041 Activate and release with no strobes -> the buffer returns to EMPTY, o_read_ready stays 0.
REQ-042 Drive i_write_activate=2'b11, then read activate with nothing committed -> o_error pulses once for each; state is unchanged.
REQ-043 Read 2 of 8 words and release; assert rst mid-write -> the buffer is freed (ready bit set); after reset o_write_ready=2'b11 and o_inactive=1.
